// File: rtl/mem_arb_pkg.sv
// +--------------------------------------------------------------------------+
// | mem_arb_pkg                                                              |
// | Shared types and constants for the RAM request arbiter.                  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    IFETCH  = 2'd1,
    DACCESS = 2'd2
  } arb_state_t;

  localparam int ADDR_W_DEF  = 32;
  localparam int DATA_W_DEF  = 32;
  localparam int TIMEOUT_DEF = 15;

  // Byte-offset bits that must be zero for a word access.
  localparam logic [1:0] ADDR_ALIGN_MASK = 2'b11;

endpackage

`default_nettype wire

// File: rtl/ram_request_arbiter_wait_timer.sv
// +--------------------------------------------------------------------------+
// | wait_timer                                                               |
// | Counts RAM wait cycles; flags the cycle that reaches TIMEOUT.            |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module wait_timer #(
  parameter int TIMEOUT = 15
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] r_count;

  // expired marks the TIMEOUT-th consecutive wait cycle, so strobes stay
  // high for exactly TIMEOUT cycles on an unanswered access.
  assign expired = enable && (r_count == CW'(TIMEOUT - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count <= '0;
    end else if (clear) begin
      r_count <= '0;
    end else if (enable && (r_count != CW'(TIMEOUT))) begin
      r_count <= r_count + CW'(1);
    end
  end

endmodule

`default_nettype wire

// File: rtl/ram_request_arbiter.sv
// +--------------------------------------------------------------------------+
// | ram_request_arbiter                                                      |
// | Shares one single-port RAM between instruction fetch and data access.    |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module ram_request_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic              d_ren,
  input  logic              d_wen,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_store,
  input  logic              ram_ack,
  input  logic [DATA_W-1:0] ram_load,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_store,
  output logic              ram_ren,
  output logic              ram_wen,
  output logic [DATA_W-1:0] imemload,
  output logic [DATA_W-1:0] dmemload,
  output logic              i_ready,
  output logic              d_ready,
  output logic              err
);

  localparam logic [ADDR_W-1:0] C_ALIGN = {{(ADDR_W-2){1'b1}}, ~ADDR_ALIGN_MASK};

  arb_state_t r_state;
  arb_state_t w_state_next;
  logic       w_grant_data;
  logic       w_grant_fetch;
  logic       w_finish;
  logic       w_timeout;
  logic       w_busy;
  logic       w_expired;
  logic       r_last_data;

  assign w_busy = (r_state != IDLE);

  wait_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_wait_timer (
    .clk     (clk),
    .reset   (reset),
    .clear   (w_grant_data | w_grant_fetch),
    .enable  (w_busy & ~ram_ack),
    .expired (w_expired)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Data normally wins; a fetch still pending right after a data access goes
  // first so neither side waits more than one transaction.
  always_comb begin
    w_state_next  = r_state;
    w_grant_data  = 1'b0;
    w_grant_fetch = 1'b0;
    w_finish      = 1'b0;
    w_timeout     = 1'b0;
    case (r_state)
      IDLE: begin
        if ((d_ren | d_wen) && !(r_last_data && i_req)) begin
          w_grant_data = 1'b1;
          w_state_next = DACCESS;
        end else if (i_req) begin
          w_grant_fetch = 1'b1;
          w_state_next  = IFETCH;
        end
      end
      IFETCH, DACCESS: begin
        if (ram_ack) begin
          w_finish     = 1'b1;
          w_state_next = IDLE;
        end else if (w_expired) begin
          w_finish     = 1'b1;
          w_timeout    = 1'b1;
          w_state_next = IDLE;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ram_addr    <= '0;
      ram_store   <= '0;
      ram_ren     <= 1'b0;
      ram_wen     <= 1'b0;
      imemload    <= '0;
      dmemload    <= '0;
      i_ready     <= 1'b0;
      d_ready     <= 1'b0;
      err         <= 1'b0;
      r_last_data <= 1'b0;
    end else begin
      i_ready <= 1'b0;
      d_ready <= 1'b0;
      if (w_grant_data) begin
        ram_addr    <= d_addr & C_ALIGN;
        ram_store   <= d_store;
        ram_wen     <= d_wen;
        ram_ren     <= d_ren & ~d_wen;
        r_last_data <= 1'b1;
        if ((d_ren & d_wen) || ((d_addr[1:0] & ADDR_ALIGN_MASK) != 2'b00)) begin
          err <= 1'b1;
        end
      end else if (w_grant_fetch) begin
        ram_addr    <= i_addr & C_ALIGN;
        ram_ren     <= 1'b1;
        ram_wen     <= 1'b0;
        r_last_data <= 1'b0;
        if ((i_addr[1:0] & ADDR_ALIGN_MASK) != 2'b00) begin
          err <= 1'b1;
        end
      end else if (w_finish) begin
        ram_ren <= 1'b0;
        ram_wen <= 1'b0;
        i_ready <= (r_state == IFETCH);
        d_ready <= (r_state == DACCESS);
        if (w_timeout) begin
          err <= 1'b1;
        end else if (r_state == IFETCH) begin
          imemload <= ram_load;
        end else if (ram_ren) begin
          dmemload <= ram_load;
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_ram_request_arbiter.sv
// +--------------------------------------------------------------------------+
// | tb_ram_request_arbiter                                                   |
// | Directed scenarios for the RAM request arbiter.                          |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_ram_request_arbiter;

  logic        clk;
  logic        reset;
  logic        i_req;
  logic [31:0] i_addr;
  logic        d_ren;
  logic        d_wen;
  logic [31:0] d_addr;
  logic [31:0] d_store;
  logic        ram_ack;
  logic [31:0] ram_load;
  logic [31:0] ram_addr;
  logic [31:0] ram_store;
  logic        ram_ren;
  logic        ram_wen;
  logic [31:0] imemload;
  logic [31:0] dmemload;
  logic        i_ready;
  logic        d_ready;
  logic        err;

  int checks;
  int failures;

  ram_request_arbiter dut (
    .clk       (clk),
    .reset     (reset),
    .i_req     (i_req),
    .i_addr    (i_addr),
    .d_ren     (d_ren),
    .d_wen     (d_wen),
    .d_addr    (d_addr),
    .d_store   (d_store),
    .ram_ack   (ram_ack),
    .ram_load  (ram_load),
    .ram_addr  (ram_addr),
    .ram_store (ram_store),
    .ram_ren   (ram_ren),
    .ram_wen   (ram_wen),
    .imemload  (imemload),
    .dmemload  (dmemload),
    .i_ready   (i_ready),
    .d_ready   (d_ready),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL global_timeout simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step();
    checks++; if (ram_ren !== 1'b0 || ram_wen !== 1'b0) begin failures++; $display("FAIL reset_strobes got ren=%b wen=%b exp 0", ram_ren, ram_wen); end
    checks++; if (ram_addr !== 32'h0) begin failures++; $display("FAIL reset_addr got=%h exp=0", ram_addr); end
    checks++; if (i_ready !== 1'b0 || d_ready !== 1'b0) begin failures++; $display("FAIL reset_ready got i=%b d=%b exp 0", i_ready, d_ready); end
    checks++; if (imemload !== 32'h0 || dmemload !== 32'h0) begin failures++; $display("FAIL reset_loads got i=%h d=%h exp 0", imemload, dmemload); end
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL reset_err got=%b exp=0", err); end
    reset = 1'b0;
    step();
  endtask

  task automatic test_idle_ack();
    ram_ack = 1'b1;
    ram_load = 32'hFFFF0000;
    step();
    ram_ack = 1'b0;
    step();
    checks++; if (i_ready !== 1'b0 || d_ready !== 1'b0 || ram_ren !== 1'b0) begin failures++; $display("FAIL idle_ack got i=%b d=%b ren=%b exp 0", i_ready, d_ready, ram_ren); end
    checks++; if (imemload !== 32'h0 || dmemload !== 32'h0) begin failures++; $display("FAIL idle_ack_loads got i=%h d=%h exp 0", imemload, dmemload); end
  endtask

  task automatic test_fetch();
    i_req = 1'b1; i_addr = 32'h104;
    step();
    i_req = 1'b0;
    checks++; if (ram_ren !== 1'b1 || ram_wen !== 1'b0 || ram_addr !== 32'h104) begin failures++; $display("FAIL fetch_issue got ren=%b wen=%b addr=%h exp 1 0 104", ram_ren, ram_wen, ram_addr); end
    step();
    checks++; if (ram_ren !== 1'b1 || ram_addr !== 32'h104 || i_ready !== 1'b0) begin failures++; $display("FAIL fetch_hold1 got ren=%b addr=%h rdy=%b exp 1 104 0", ram_ren, ram_addr, i_ready); end
    step();
    checks++; if (ram_ren !== 1'b1 || ram_addr !== 32'h104) begin failures++; $display("FAIL fetch_hold2 got ren=%b addr=%h exp 1 104", ram_ren, ram_addr); end
    ram_ack = 1'b1; ram_load = 32'h00A00093;
    step();
    ram_ack = 1'b0; ram_load = 32'h0;
    checks++; if (i_ready !== 1'b1 || ram_ren !== 1'b0) begin failures++; $display("FAIL fetch_done got rdy=%b ren=%b exp 1 0", i_ready, ram_ren); end
    checks++; if (imemload !== 32'h00A00093) begin failures++; $display("FAIL fetch_imem got=%h exp=00a00093", imemload); end
    step();
    checks++; if (i_ready !== 1'b0 || d_ready !== 1'b0 || err !== 1'b0) begin failures++; $display("FAIL fetch_pulse got i=%b d=%b err=%b exp 0 0 0", i_ready, d_ready, err); end
  endtask

  task automatic test_priority();
    i_req = 1'b1; i_addr = 32'h300;
    d_ren = 1'b1; d_addr = 32'h200;
    step();
    d_ren = 1'b0;
    checks++; if (ram_addr !== 32'h200 || ram_ren !== 1'b1 || ram_wen !== 1'b0) begin failures++; $display("FAIL prio_data_first got addr=%h ren=%b wen=%b exp 200 1 0", ram_addr, ram_ren, ram_wen); end
    ram_ack = 1'b1; ram_load = 32'h11112222;
    step();
    ram_ack = 1'b0;
    checks++; if (d_ready !== 1'b1 || i_ready !== 1'b0) begin failures++; $display("FAIL prio_d_ready got d=%b i=%b exp 1 0", d_ready, i_ready); end
    checks++; if (dmemload !== 32'h11112222) begin failures++; $display("FAIL prio_dmem got=%h exp=11112222", dmemload); end
    step();
    i_req = 1'b0;
    checks++; if (ram_addr !== 32'h300 || ram_ren !== 1'b1) begin failures++; $display("FAIL prio_fetch_next got addr=%h ren=%b exp 300 1", ram_addr, ram_ren); end
    ram_ack = 1'b1; ram_load = 32'h33334444;
    step();
    ram_ack = 1'b0;
    checks++; if (i_ready !== 1'b1 || d_ready !== 1'b0 || imemload !== 32'h33334444) begin failures++; $display("FAIL prio_i_ready got i=%b d=%b imem=%h exp 1 0 33334444", i_ready, d_ready, imemload); end
    step();
  endtask

  task automatic test_write();
    d_wen = 1'b1; d_addr = 32'h40; d_store = 32'hDEADBEEF;
    step();
    d_wen = 1'b0; d_store = 32'h0;
    checks++; if (ram_wen !== 1'b1 || ram_ren !== 1'b0 || ram_addr !== 32'h40) begin failures++; $display("FAIL write_issue got wen=%b ren=%b addr=%h exp 1 0 40", ram_wen, ram_ren, ram_addr); end
    checks++; if (ram_store !== 32'hDEADBEEF) begin failures++; $display("FAIL write_store got=%h exp=deadbeef", ram_store); end
    ram_ack = 1'b1; ram_load = 32'h55555555;
    step();
    ram_ack = 1'b0;
    checks++; if (d_ready !== 1'b1 || ram_wen !== 1'b0) begin failures++; $display("FAIL write_done got rdy=%b wen=%b exp 1 0", d_ready, ram_wen); end
    checks++; if (dmemload !== 32'h11112222 || err !== 1'b0) begin failures++; $display("FAIL write_dmem_err got dmem=%h err=%b exp 11112222 0", dmemload, err); end
    step();
  endtask

  task automatic test_timeout();
    int n;
    d_ren = 1'b1; d_addr = 32'h80;
    step();
    d_ren = 1'b0;
    ram_load = 32'h77777777;
    n = 0;
    while (ram_ren === 1'b1 && n < 40) begin
      checks++; if (d_ready !== 1'b0) begin failures++; $display("FAIL timeout_early_ready at wait=%0d got=%b exp=0", n, d_ready); end
      n++;
      step();
    end
    checks++; if (n != 15) begin failures++; $display("FAIL timeout_len got=%0d exp=15", n); end
    checks++; if (d_ready !== 1'b1 || err !== 1'b1) begin failures++; $display("FAIL timeout_abort got rdy=%b err=%b exp 1 1", d_ready, err); end
    checks++; if (dmemload !== 32'h11112222) begin failures++; $display("FAIL timeout_dmem got=%h exp=11112222", dmemload); end
    step();
    i_req = 1'b1; i_addr = 32'h108;
    step();
    i_req = 1'b0;
    checks++; if (ram_ren !== 1'b1 || ram_addr !== 32'h108) begin failures++; $display("FAIL timeout_next_fetch got ren=%b addr=%h exp 1 108", ram_ren, ram_addr); end
    ram_ack = 1'b1; ram_load = 32'h00000013;
    step();
    ram_ack = 1'b0;
    checks++; if (i_ready !== 1'b1 || imemload !== 32'h00000013 || err !== 1'b1) begin failures++; $display("FAIL timeout_after got rdy=%b imem=%h err=%b exp 1 13 1", i_ready, imemload, err); end
    step();
  endtask

  task automatic test_mid_reset();
    i_req = 1'b1; i_addr = 32'h10C;
    step();
    i_req = 1'b0;
    checks++; if (ram_ren !== 1'b1) begin failures++; $display("FAIL midrst_issue got ren=%b exp=1", ram_ren); end
    step();
    #2 reset = 1'b1;
    #1;
    checks++; if (ram_ren !== 1'b0 || err !== 1'b0) begin failures++; $display("FAIL midrst_async got ren=%b err=%b exp 0 0", ram_ren, err); end
    checks++; if (imemload !== 32'h0) begin failures++; $display("FAIL midrst_imem got=%h exp=0", imemload); end
    ram_ack = 1'b1; ram_load = 32'h99999999;
    step();
    reset = 1'b0; ram_ack = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      checks++; if (i_ready !== 1'b0 || ram_ren !== 1'b0 || imemload !== 32'h0) begin failures++; $display("FAIL midrst_quiet cyc=%0d got rdy=%b ren=%b imem=%h exp 0 0 0", k, i_ready, ram_ren, imemload); end
    end
  endtask

  task automatic test_both_misaligned();
    d_ren = 1'b1; d_wen = 1'b1; d_addr = 32'h43; d_store = 32'hCAFEF00D;
    step();
    d_ren = 1'b0; d_wen = 1'b0;
    checks++; if (ram_wen !== 1'b1 || ram_ren !== 1'b0 || ram_addr !== 32'h40) begin failures++; $display("FAIL both_issue got wen=%b ren=%b addr=%h exp 1 0 40", ram_wen, ram_ren, ram_addr); end
    checks++; if (err !== 1'b1 || ram_store !== 32'hCAFEF00D) begin failures++; $display("FAIL both_err got err=%b store=%h exp 1 cafef00d", err, ram_store); end
    ram_ack = 1'b1; ram_load = 32'h12345678;
    step();
    ram_ack = 1'b0;
    checks++; if (d_ready !== 1'b1 || dmemload !== 32'h0) begin failures++; $display("FAIL both_done got rdy=%b dmem=%h exp 1 0", d_ready, dmemload); end
    step();
  endtask

  initial begin
    checks = 0; failures = 0;
    reset = 1'b1; i_req = 1'b0; i_addr = '0; d_ren = 1'b0; d_wen = 1'b0;
    d_addr = '0; d_store = '0; ram_ack = 1'b0; ram_load = '0;
    test_reset();
    test_idle_ack();
    test_fetch();
    test_priority();
    test_write();
    test_timeout();
    test_mid_reset();
    test_both_misaligned();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
